l2_victim_buffer: RTL and testbench

L2_VICTIM_BUFFER -- requirements
Module: l2_victim_buffer

---
 rtl/l2_victim_buffer.sv | 177 +++++++++++++++++
 tb/tb_l2_victim_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_victim_buffer.sv
// Victim write buffer between L2 and memory: FIFO of dirty lines with coalescing.
// Optional read forwarding from buffered lines when L2_VICTIM_FWD_EN is defined.
module l2_victim_buffer #(
    parameter int DEPTH    = 4,
    parameter int s_offset = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int TAG_W = 32 - s_offset;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RD_MEM,
        WR_MEM
    } state_t;

    state_t state, state_n;

    logic [DEPTH-1:0] valid;
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [255:0]     data_q [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic [TAG_W-1:0] rd_tag;

    logic [TAG_W-1:0] req_tag;
    logic             full;
    logic             w_hit;
    logic [PTR_W-1:0] w_idx;
    logic             head_conflict;
    logic             wr_ok;
    logic             wr_coal;
    logic             wr_alloc;
    logic             pop;
    logic             unused_bits;

    assign req_tag     = mem_address[31:s_offset];
    assign unused_bits = ^mem_address[s_offset-1:0];
    assign full        = (count == CNT_W'(DEPTH));

`ifdef L2_VICTIM_FWD_EN
    logic             r_hit;
    logic [PTR_W-1:0] r_idx;
`endif

    // Scan oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx           = head;
        w_hit         = 1'b0;
        w_idx         = '0;
        head_conflict = 1'b0;
`ifdef L2_VICTIM_FWD_EN
        r_hit         = 1'b0;
        r_idx         = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && tag_q[idx] == req_tag) begin
`ifdef L2_VICTIM_FWD_EN
                r_hit = 1'b1;
                r_idx = idx;
`endif
                if (state == WR_MEM && idx == head) begin
                    head_conflict = 1'b1;
                end else begin
                    w_hit = 1'b1;
                    w_idx = idx;
                end
            end
        end
    end

    assign wr_ok    = (state == IDLE || state == WR_MEM) && mem_write
                      && !mem_read && !head_conflict;
    assign wr_coal  = wr_ok && w_hit;
    assign wr_alloc = wr_ok && !w_hit && !full;
    assign pop      = (state == WR_MEM) && pmem_resp;

    always_comb begin
        state_n      = state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        unique case (state)
            IDLE: begin
                if (mem_read) begin
`ifdef L2_VICTIM_FWD_EN
                    if (r_hit) begin
                        mem_resp  = 1'b1;
                        mem_rdata = data_q[r_idx];
                    end else begin
                        state_n = RD_MEM;
                    end
`else
                    // Without forwarding the buffer must be empty first.
                    if (count == '0) state_n = RD_MEM;
                    else             state_n = WR_MEM;
`endif
                end else begin
                    mem_resp = wr_coal || wr_alloc;
                    if (count != '0) state_n = WR_MEM;
                end
            end
            RD_MEM: begin
                pmem_read    = 1'b1;
                pmem_address = {rd_tag, {s_offset{1'b0}}};
                if (pmem_resp) begin
                    mem_resp  = 1'b1;
                    mem_rdata = pmem_rdata;
                    state_n   = IDLE;
                end
            end
            WR_MEM: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[head], {s_offset{1'b0}}};
                pmem_wdata   = data_q[head];
                mem_resp     = wr_coal || wr_alloc;
                if (pmem_resp) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            valid  <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rd_tag <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == RD_MEM) rd_tag <= req_tag;
            if (wr_alloc) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_alloc) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (wr_alloc) begin
            tag_q[tail]  <= req_tag;
            data_q[tail] <= mem_wdata;
        end else if (wr_coal) begin
            data_q[w_idx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_l2_victim_buffer.sv
// Directed bench for l2_victim_buffer with drain and read scoreboards.
module tb_l2_victim_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  mem_address = '0;
    logic [255:0] mem_wdata = '0;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    l2_victim_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
    } line_t;

    int           n_cmp = 0;
    int           n_bad = 0;
    bit           hold = 1'b0;
    int           lat = 1;
    int           pm_cnt = 0;
    line_t        sbq[$];
    logic [255:0] rdq[$];
    logic [255:0] mem [logic [31:0]];

    function automatic logic [255:0] pat(logic [31:0] a);
        return {8{a ^ 32'hA5A5_0000}};
    endfunction

    function automatic logic [255:0] dv(int k);
        return {8{32'hD000_0000 + k}};
    endfunction

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(logic [31:0] a, logic [255:0] d);
        bit found = 1'b0;
        foreach (sbq[i]) begin
            if (sbq[i].addr == a) begin
                sbq[i].data = d;
                found = 1'b1;
            end
        end
        if (!found) sbq.push_back('{addr: a, data: d});
    endtask

    // Memory model: answers after lat request cycles unless hold is set.
    always begin
        @(posedge clk);
        #1;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        if (rst) begin
            pm_cnt = 0;
        end else if (pmem_read || pmem_write) begin
            chk("pmem_excl", pmem_read && pmem_write, 0);
            if (!hold) begin
                pm_cnt++;
                if (pm_cnt >= lat) begin
                    pm_cnt    = 0;
                    pmem_resp = 1'b1;
                    if (pmem_read) begin
                        pmem_rdata = mem.exists(pmem_address)
                                     ? mem[pmem_address] : pat(pmem_address);
                    end else begin
                        chk("drain_pending", sbq.size() != 0, 1);
                        if (sbq.size() != 0) begin
                            chk("drain_addr", pmem_address, sbq[0].addr);
                            chk("drain_data", pmem_wdata, sbq[0].data);
                            void'(sbq.pop_front());
                        end
                        mem[pmem_address] = pmem_wdata;
                    end
                end
            end
        end else begin
            pm_cnt = 0;
        end
    end

    task automatic wr(input logic [31:0] a, input logic [255:0] d,
                      input int maxc, output int n, output bit acked);
        mem_write   = 1'b1;
        mem_address = a;
        mem_wdata   = d;
        n     = 0;
        acked = 1'b0;
        while (!acked && n < maxc) begin
            @(negedge clk);
            if (mem_resp) begin
                acked = 1'b1;
                model_write(a, d);
            end
            @(posedge clk);
            #1;
            n++;
        end
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [255:0] exp,
                      input int maxc, output int preads, output int n);
        bit done = 1'b0;
        rdq.push_back(exp);
        mem_read    = 1'b1;
        mem_address = a;
        preads = 0;
        n      = 0;
        while (!done && n < maxc) begin
            @(negedge clk);
            if (pmem_read) preads++;
            if (mem_resp) begin
                done = 1'b1;
                chk("rd_data", mem_rdata, rdq.pop_front());
            end else begin
                chk("rd_idle_zero", mem_rdata, 0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk("rd_done", done, 1);
        rdq.delete();
        mem_read    = 1'b0;
        mem_address = '0;
    endtask

    task automatic wait_empty(input int maxc);
        int n = 0;
        while ((dut.count != 0 || sbq.size() != 0) && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        chk("drain_count", dut.count, 0);
        chk("drain_sbq", sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pr, nr;
        bit ok;
        logic [31:0] a4 [4];
        a4[0] = 32'h100;
        a4[1] = 32'h200;
        a4[2] = 32'h300;
        a4[3] = 32'h400;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_addr", pmem_address, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_count", dut.count, 0);
        @(posedge clk);
        #1;

        // single write then drain
        lat = 1;
        wr(32'h1000, dv(0), 4, n, ok);
        chk("w1000_ack", ok, 1);
        chk("w1000_lat", n, 1);
        chk("w1000_cnt", dut.count, 1);
        wait_empty(20);

        // fill, stall fifth write until a slot frees
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr(a4[i], dv(i + 1), 4, n, ok);
            chk("fill_ack", ok, 1);
            chk("fill_lat", n, 1);
        end
        chk("full_cnt", dut.count, 4);
        fork
            wr(32'h500, dv(5), 20, n, ok);
            begin
                repeat (5) @(posedge clk);
                hold = 1'b0;
            end
        join
        chk("w500_ack", ok, 1);
        chk("w500_wait", n, 7);
        wait_empty(40);

        // read after write
        wr(32'h2000, dv(6), 4, n, ok);
        chk("w2000_ack", ok, 1);
        rd(32'h2000, dv(6), 20, pr, nr);
`ifdef L2_VICTIM_FWD_EN
        chk("r2000_preads", pr, 0);
        chk("r2000_lat", nr, 1);
        chk("r2000_sbq", sbq.size(), 1);
`else
        chk("r2000_preads", pr, 1);
        chk("r2000_sbq", sbq.size(), 0);
`endif
        wait_empty(20);

        // coalescing while another line drains, head stall
        hold = 1'b1;
        wr(32'h3100, dv(7), 4, n, ok);
        chk("w3100_ack", ok, 1);
        wr(32'h3000, dv(8), 4, n, ok);
        chk("w3000a_lat", n, 1);
        wr(32'h3000, dv(9), 4, n, ok);
        chk("w3000b_lat", n, 1);
        chk("coal_cnt", dut.count, 2);
        wr(32'h3100, dv(10), 3, n, ok);
        chk("head_stall", ok, 0);
        chk("stall_cnt", dut.count, 2);
        hold = 1'b0;
        wait_empty(30);

        // read miss with slow memory
        lat = 5;
        wr(32'h5000, dv(11), 4, n, ok);
        chk("w5000_ack", ok, 1);
        rd(32'h4000, pat(32'h4000), 40, pr, nr);
        chk("r4000_preads", pr, 5);
`ifdef L2_VICTIM_FWD_EN
        chk("r4000_cnt", dut.count, 1);
`else
        chk("r4000_cnt", dut.count, 0);
`endif
        wait_empty(30);
        lat = 1;

        // reset in the middle of a drain
        hold = 1'b1;
        wr(32'h6000, dv(12), 4, n, ok);
        chk("w6000_ack", ok, 1);
        wr(32'h6100, dv(13), 4, n, ok);
        chk("w6100_ack", ok, 1);
        wr(32'h6200, dv(14), 4, n, ok);
        chk("w6200_ack", ok, 1);
        @(negedge clk);
        chk("pre_rst_write", pmem_write, 1);
        chk("pre_rst_addr", pmem_address, 32'h6000);
        chk("pre_rst_cnt", dut.count, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_write", pmem_write, 0);
        chk("post_rst_cnt", dut.count, 0);
        sbq.delete();
        hold = 1'b0;
        @(posedge clk);
        #1;
        rd(32'h6100, pat(32'h6100), 20, pr, nr);
        chk("r6100_preads", pr, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
